sc1_port_uart_tx: RTL

//   UART transmitter peripheral attached to the sc1_cpu output/input port pair.
//   The CPU has no port strobe, so software requests a byte by writing port_out

---
 rtl/sc1_port_uart_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sc1_port_uart_tx.sv
// UART 8N1 transmitter on the sc1_cpu port pair: toggle-handshake request/ack,
// one holding register in front of the shift register so frames can run back to back.
module sc1_port_uart_tx #(
    parameter int WIDTH_D   = 32,
    parameter int BAUD_DIV  = 104,
    parameter int DIV_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH_D-1:0] cpu_port_out,
    output logic [WIDTH_D-1:0] cpu_port_in,
    output logic               uart_txd
);
    // state | meaning
    // IDLE  | line high, waiting for the holding register to fill
    // START | start bit (low) for BAUD_DIV clocks
    // DATA  | data bits LSB first, BAUD_DIV clocks each
    // STOP  | stop bit (high); reload from hold here for gapless frames
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [DIV_WIDTH-1:0] BAUD_LAST = DIV_WIDTH'(BAUD_DIV - 1);

    state_t               state;
    logic                 req_r;
    logic [7:0]           byte_r;
    logic [7:0]           hold_q;
    logic [7:0]           shift_q;
    logic                 hold_full;
    logic                 ack;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [2:0]           bit_idx;

    logic bit_end;
    logic accept;
    logic frame_end;
    logic load;
    logic hold_full_n;
    logic ack_n;
    logic busy_n;
    logic unused_port_hi;

    assign unused_port_hi = ^cpu_port_out[WIDTH_D-1:9];

    assign bit_end     = (baud_cnt == '0);
    assign accept      = (req_r != ack) && !hold_full;
    assign frame_end   = (state == STOP) && bit_end;
    assign load        = hold_full && ((state == IDLE) || frame_end);
    assign hold_full_n = load ? 1'b0 : (accept ? 1'b1 : hold_full);
    assign ack_n       = accept ? req_r : ack;
    // port_in is registered from next-state values so ack shows two edges after a write
    assign busy_n      = hold_full_n | load | ((state != IDLE) && !frame_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_r       <= 1'b0;
            byte_r      <= 8'h00;
            hold_q      <= 8'h00;
            shift_q     <= 8'h00;
            hold_full   <= 1'b0;
            ack         <= 1'b0;
            baud_cnt    <= BAUD_LAST;
            bit_idx     <= 3'd0;
            uart_txd    <= 1'b1;
            cpu_port_in <= '0;
        end else begin
            req_r       <= cpu_port_out[8];
            byte_r      <= cpu_port_out[7:0];
            hold_full   <= hold_full_n;
            ack         <= ack_n;
            cpu_port_in <= WIDTH_D'({hold_full_n, busy_n, ack_n});
            if (accept) begin
                hold_q <= byte_r;
            end

            if (load) begin
                shift_q  <= hold_q;
                state    <= START;
                baud_cnt <= BAUD_LAST;
                bit_idx  <= 3'd0;
                uart_txd <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        uart_txd <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state    <= DATA;
                            baud_cnt <= BAUD_LAST;
                            bit_idx  <= 3'd0;
                            uart_txd <= shift_q[0];
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= BAUD_LAST;
                            if (bit_idx == 3'd7) begin
                                state    <= STOP;
                                uart_txd <= 1'b1;
                            end else begin
                                bit_idx  <= bit_idx + 3'd1;
                                uart_txd <= shift_q[bit_idx + 3'd1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state    <= IDLE;
                            uart_txd <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        uart_txd <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
